rename_wide: RTL and testbench

RENAME_WIDE -- requirements
Module: rename_wide

---
 rtl/rename_wide.sv | 142 ++++++++++++++
 tb/tb_rename_wide.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_wide.sv
// Register renaming stage: maps GPR/FPR operands onto in-flight ROB ids using a
// valid/id map table, with intra-group bypass, commit clearing and flush.
module rename_wide #(
  parameter int ROB_DEPTH = 16,
  parameter int DEC_WIDTH = 2,
  parameter int COM_WIDTH = 2,
  parameter int NREG      = 32,
  localparam int ROB      = $clog2(ROB_DEPTH),
  localparam int NREG_W   = $clog2(NREG),
  localparam int AW       = (NREG_W > ROB) ? NREG_W : ROB,
  localparam int RF_W     = 2 + AW
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_,
  input  logic [DEC_WIDTH-1:0]                dec_e_,
  input  logic [DEC_WIDTH-1:0]                dec_invalid,
  input  logic [DEC_WIDTH-1:0][RF_W-1:0]      dec_rd,
  input  logic [DEC_WIDTH-1:0][RF_W-1:0]      dec_rs1,
  input  logic [DEC_WIDTH-1:0][RF_W-1:0]      dec_rs2,
  input  logic [ROB-1:0]                      dec_rob_id,
  output logic [DEC_WIDTH-1:0]                ren_e_,
  output logic [DEC_WIDTH-1:0][RF_W-1:0]      ren_rd,
  output logic [DEC_WIDTH-1:0][RF_W-1:0]      ren_rs1,
  output logic [DEC_WIDTH-1:0][RF_W-1:0]      ren_rs2,
  input  logic [COM_WIDTH-1:0]                commit_e_,
  input  logic [COM_WIDTH-1:0][ROB-1:0]       com_rob_id
);

  // Operand type encoding in the top two bits of a RegFile_t field.
  localparam logic [1:0] TYPE_GPR = 2'd0;
  localparam logic [1:0] TYPE_FPR = 2'd1;
  localparam logic [1:0] TYPE_ROB = 2'd2;

  logic [1:0][NREG-1:0]           map_valid_q, map_valid_d, valid_eff;
  logic [ROB-1:0]                 map_id_q [2][NREG];
  logic [ROB-1:0]                 map_id_d [2][NREG];

  logic [DEC_WIDTH-1:0]           ren_e_q, ren_e_d;
  logic [DEC_WIDTH-1:0][RF_W-1:0] ren_rd_q, ren_rd_d;
  logic [DEC_WIDTH-1:0][RF_W-1:0] ren_rs1_q, ren_rs1_d;
  logic [DEC_WIDTH-1:0][RF_W-1:0] ren_rs2_q, ren_rs2_d;

  logic [DEC_WIDTH-1:0]           active, producer;
  logic [DEC_WIDTH-1:0][ROB-1:0]  slot_id;
  logic [RF_W-1:0]                op, res;

  function automatic logic renameable(input logic [RF_W-1:0] f);
    return ((f[RF_W-1 -: 2] == TYPE_GPR) && (f[AW-1:0] != '0)) ||
           (f[RF_W-1 -: 2] == TYPE_FPR);
  endfunction

  function automatic logic [RF_W-1:0] rob_op(input logic [ROB-1:0] id);
    return {TYPE_ROB, AW'(id)};
  endfunction

  always_comb begin
    valid_eff = map_valid_q;
    active    = '0;
    producer  = '0;
    slot_id   = '0;
    op        = '0;
    res       = '0;
    ren_e_d   = '1;
    ren_rd_d  = '0;
    ren_rs1_d = '0;
    ren_rs2_d = '0;

    // Commit clears are visible to this cycle's lookups.
    for (int unsigned t = 0; t < 2; t++)
      for (int unsigned a = 0; a < NREG; a++)
        for (int unsigned p = 0; p < COM_WIDTH; p++)
          if (!commit_e_[p] && map_valid_q[t][a] && (map_id_q[t][a] == com_rob_id[p]))
            valid_eff[t][a] = 1'b0;

    for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
      slot_id[i]  = dec_rob_id + ROB'(i);
      active[i]   = !dec_e_[i] && flush_;
      producer[i] = active[i] && !dec_invalid[i] && renameable(dec_rd[i]);
    end

    for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        op  = (k == 0) ? dec_rs1[i] : dec_rs2[i];
        res = op;
        if (renameable(op)) begin
          if (valid_eff[op[RF_W-2]][op[NREG_W-1:0]])
            res = rob_op(map_id_q[op[RF_W-2]][op[NREG_W-1:0]]);
          // Later (younger) matching producers override, so the youngest wins.
          for (int unsigned j = 0; j < DEC_WIDTH; j++)
            if (j < i && producer[j] && (dec_rd[j] == op))
              res = rob_op(slot_id[j]);
        end
        if (active[i]) begin
          if (k == 0) ren_rs1_d[i] = res;
          else        ren_rs2_d[i] = res;
        end
      end
      if (active[i]) begin
        ren_e_d[i]  = 1'b0;
        ren_rd_d[i] = producer[i] ? rob_op(slot_id[i]) : dec_rd[i];
      end
    end
  end

  always_comb begin
    map_valid_d = flush_ ? valid_eff : '0;
    map_id_d    = map_id_q;
    // Writes applied oldest to youngest, after commit clears.
    for (int unsigned i = 0; i < DEC_WIDTH; i++)
      if (producer[i]) begin
        map_valid_d[dec_rd[i][RF_W-2]][dec_rd[i][NREG_W-1:0]] = 1'b1;
        map_id_d[dec_rd[i][RF_W-2]][dec_rd[i][NREG_W-1:0]]    = slot_id[i];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_valid_q <= '0;
      for (int unsigned t = 0; t < 2; t++)
        for (int unsigned a = 0; a < NREG; a++)
          map_id_q[t][a] <= '0;
      ren_e_q   <= '1;
      ren_rd_q  <= '0;
      ren_rs1_q <= '0;
      ren_rs2_q <= '0;
    end else begin
      map_valid_q <= map_valid_d;
      map_id_q    <= map_id_d;
      ren_e_q     <= ren_e_d;
      ren_rd_q    <= ren_rd_d;
      ren_rs1_q   <= ren_rs1_d;
      ren_rs2_q   <= ren_rs2_d;
    end
  end

  assign ren_e_  = ren_e_q;
  assign ren_rd  = ren_rd_q;
  assign ren_rs1 = ren_rs1_q;
  assign ren_rs2 = ren_rs2_q;

endmodule

// File: tb/tb_rename_wide.sv
// Bench for rename_wide: directed scenarios followed by random traffic, checked
// against a behavioural map-table model.
module tb_rename_wide;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int RW = 7;
  localparam logic [1:0] T_GPR = 2'd0;
  localparam logic [1:0] T_FPR = 2'd1;
  localparam logic [1:0] T_ROB = 2'd2;

  logic clk = 1'b0;
  logic reset, flush_;
  logic [DW-1:0]         dec_e_, dec_invalid;
  logic [DW-1:0][RW-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [3:0]            dec_rob_id;
  logic [DW-1:0]         ren_e_;
  logic [DW-1:0][RW-1:0] ren_rd, ren_rs1, ren_rs2;
  logic [CW-1:0]         commit_e_;
  logic [CW-1:0][3:0]    com_rob_id;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_v   [2][32];
  int m_id  [2][32];
  bit m_clr [2][32];
  logic [DW-1:0]         exp_e;
  logic [DW-1:0][RW-1:0] exp_rd, exp_rs1, exp_rs2;

  always #5 clk = ~clk;

  rename_wide #(.ROB_DEPTH(16), .DEC_WIDTH(2), .COM_WIDTH(2), .NREG(32)) dut (
    .clk(clk), .reset(reset), .flush_(flush_),
    .dec_e_(dec_e_), .dec_invalid(dec_invalid),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rob_id(dec_rob_id),
    .ren_e_(ren_e_), .ren_rd(ren_rd), .ren_rs1(ren_rs1), .ren_rs2(ren_rs2),
    .commit_e_(commit_e_), .com_rob_id(com_rob_id)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [RW-1:0] gpr(input int a); return {T_GPR, 5'(a)}; endfunction
  function automatic logic [RW-1:0] fpr(input int a); return {T_FPR, 5'(a)}; endfunction
  function automatic logic [RW-1:0] rob(input int id); return {T_ROB, 5'(id % 16)}; endfunction

  function automatic bit renameable(input logic [RW-1:0] f);
    return (f[6:5] == T_GPR && f[4:0] != 5'd0) || (f[6:5] == T_FPR);
  endfunction

  function automatic bit is_active(input int i);
    return !dec_e_[i] && flush_;
  endfunction

  function automatic bit is_prod(input int i);
    return is_active(i) && !dec_invalid[i] && renameable(dec_rd[i]);
  endfunction

  function automatic logic [RW-1:0] mlook(input logic [RW-1:0] f, input int i);
    int t, a;
    if (!renameable(f)) return f;
    for (int j = i - 1; j >= 0; j--)
      if (is_prod(j) && dec_rd[j] == f) return rob(int'(dec_rob_id) + j);
    t = (f[6:5] == T_FPR) ? 1 : 0;
    a = int'(f[4:0]);
    if (m_v[t][a] && !m_clr[t][a]) return rob(m_id[t][a]);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_e_ = '1; dec_invalid = '0; flush_ = 1'b1; commit_e_ = '1;
    dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rob_id = '0; com_rob_id = '0;
  endtask

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 32; a++) begin
        m_v[t][a] = 1'b0; m_id[t][a] = 0;
      end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_e"}, 32'(ren_e_), 32'h3);
    chk({tag, "_rd"}, 32'(ren_rd), 32'h0);
    chk({tag, "_rs"}, 32'({ren_rs1, ren_rs2}), 32'h0);
  endtask

  // One clock with the currently driven inputs; checks every output slot.
  task automatic step();
    int t;
    for (int tt = 0; tt < 2; tt++)
      for (int a = 0; a < 32; a++) m_clr[tt][a] = 1'b0;
    if (flush_)
      for (int p = 0; p < CW; p++)
        if (!commit_e_[p])
          for (int tt = 0; tt < 2; tt++)
            for (int a = 0; a < 32; a++)
              if (m_v[tt][a] && m_id[tt][a] == int'(com_rob_id[p])) m_clr[tt][a] = 1'b1;
    for (int i = 0; i < DW; i++) begin
      if (is_active(i)) begin
        exp_e[i]   = 1'b0;
        exp_rd[i]  = is_prod(i) ? rob(int'(dec_rob_id) + i) : dec_rd[i];
        exp_rs1[i] = mlook(dec_rs1[i], i);
        exp_rs2[i] = mlook(dec_rs2[i], i);
      end else begin
        exp_e[i] = 1'b1; exp_rd[i] = '0; exp_rs1[i] = '0; exp_rs2[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    if (!flush_) model_clear();
    else begin
      for (int tt = 0; tt < 2; tt++)
        for (int a = 0; a < 32; a++)
          if (m_clr[tt][a]) m_v[tt][a] = 1'b0;
      for (int i = 0; i < DW; i++)
        if (is_prod(i)) begin
          t = (dec_rd[i][6:5] == T_FPR) ? 1 : 0;
          m_v[t][int'(dec_rd[i][4:0])]  = 1'b1;
          m_id[t][int'(dec_rd[i][4:0])] = (int'(dec_rob_id) + i) % 16;
        end
    end
    chk("ren_e", 32'(ren_e_), 32'(exp_e));
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("ren_rd%0d", i),  32'(ren_rd[i]),  32'(exp_rd[i]));
      chk($sformatf("ren_rs1_%0d", i), 32'(ren_rs1[i]), 32'(exp_rs1[i]));
      chk($sformatf("ren_rs2_%0d", i), 32'(ren_rs2[i]), 32'(exp_rs2[i]));
    end
  endtask

  function automatic logic [RW-1:0] rnd_op();
    int r;
    r = $urandom_range(0, 15);
    if (r < 7)       return gpr($urandom_range(0, 3));
    else if (r < 14) return fpr($urandom_range(0, 3));
    else if (r == 14) return rob($urandom_range(0, 15));
    else             return {2'd3, 5'($urandom_range(0, 31))};
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    chk_reset_outs("reset_hold");
    #12 reset = 1'b0;

    // Map x1 -> 4; its own rs1 of x1 is not forwarded.
    dec_e_ = 2'b10; dec_rob_id = 4'd4;
    dec_rd[0] = gpr(1); dec_rs1[0] = gpr(1); dec_rs2[0] = gpr(0);
    step();
    chk("g1_rd0", 32'(ren_rd[0]), 32'(rob(4)));
    chk("g1_rs1_nofwd", 32'(ren_rs1[0]), 32'(gpr(1)));
    dec_rob_id = 4'd6; dec_rd[0] = gpr(9); dec_rs1[0] = gpr(1);
    step();
    chk("g2_rs1_x1", 32'(ren_rs1[0]), 32'(rob(4)));

    // Intra-group bypass and x0 passthrough.
    dec_e_ = 2'b00; dec_rob_id = 4'd7;
    dec_rd[0] = gpr(3); dec_rs1[0] = gpr(0); dec_rs2[0] = gpr(0);
    dec_rd[1] = gpr(4); dec_rs1[1] = gpr(3); dec_rs2[1] = gpr(0);
    step();
    chk("byp_rd0", 32'(ren_rd[0]), 32'(rob(7)));
    chk("byp_rd1", 32'(ren_rd[1]), 32'(rob(8)));
    chk("byp_rs1_1", 32'(ren_rs1[1]), 32'(rob(7)));
    chk("byp_rs2_1", 32'(ren_rs2[1]), 32'(gpr(0)));

    // Wrap 15 -> 0, youngest write wins.
    dec_rob_id = 4'd15; dec_rd[0] = fpr(5); dec_rd[1] = fpr(5);
    dec_rs1 = '0; dec_rs2 = '0;
    step();
    chk("wrap_rd0", 32'(ren_rd[0]), 32'(rob(15)));
    chk("wrap_rd1", 32'(ren_rd[1]), 32'(rob(0)));
    dec_e_ = 2'b10; dec_rob_id = 4'd1; dec_rd[0] = gpr(0); dec_rs1[0] = fpr(5);
    step();
    chk("f5_read", 32'(ren_rs1[0]), 32'(rob(0)));
    chk("x0_rd", 32'(ren_rd[0]), 32'(gpr(0)));
    dec_rob_id = 4'd2; dec_rs1[0] = gpr(0);
    step();
    chk("x0_nomap", 32'(ren_rs1[0]), 32'(gpr(0)));

    // Remap x1 -> 5, commit the stale id, then commit the live one with a read.
    dec_rob_id = 4'd5; dec_rd[0] = gpr(1); dec_rs1[0] = gpr(0);
    step();
    dec_rob_id = 4'd6; dec_rd[0] = gpr(0); dec_rs1[0] = gpr(1);
    commit_e_ = 2'b10; com_rob_id[0] = 4'd4;
    step();
    chk("x1_after_c4", 32'(ren_rs1[0]), 32'(rob(5)));
    commit_e_ = 2'b01; com_rob_id[1] = 4'd5;
    step();
    chk("x1_commit_byp", 32'(ren_rs1[0]), 32'(gpr(1)));

    // Decode write beats same-cycle commit on the same entry.
    commit_e_ = '1; dec_rob_id = 4'd9; dec_rd[0] = gpr(7); dec_rs1[0] = gpr(0);
    step();
    commit_e_ = 2'b10; com_rob_id[0] = 4'd9; dec_rob_id = 4'd10;
    step();
    commit_e_ = '1; dec_rob_id = 4'd11; dec_rd[0] = gpr(0); dec_rs1[0] = gpr(7);
    step();
    chk("wr_beats_commit", 32'(ren_rs1[0]), 32'(rob(10)));

    // Invalid slot: reported, but neither bypasses nor maps.
    dec_e_ = 2'b00; dec_invalid = 2'b01; dec_rob_id = 4'd12;
    dec_rd[0] = gpr(6); dec_rs1[0] = gpr(0);
    dec_rd[1] = gpr(12); dec_rs1[1] = gpr(6);
    step();
    chk("inv_e", 32'(ren_e_), 32'h0);
    chk("inv_rd0", 32'(ren_rd[0]), 32'(gpr(6)));
    chk("inv_nobyp", 32'(ren_rs1[1]), 32'(gpr(6)));
    dec_invalid = '0; dec_e_ = 2'b10; dec_rob_id = 4'd14;
    dec_rd[0] = gpr(0); dec_rs1[0] = gpr(6);
    step();
    chk("inv_nomap", 32'(ren_rs1[0]), 32'(gpr(6)));

    // Flush drops the group and clears all mappings.
    dec_rob_id = 4'd11; dec_rd[0] = gpr(2); dec_rs1[0] = gpr(0);
    step();
    flush_ = 1'b0; dec_e_ = 2'b00; dec_rob_id = 4'd6;
    dec_rd[0] = gpr(2); dec_rd[1] = gpr(2); commit_e_ = 2'b10; com_rob_id[0] = 4'd10;
    step();
    chk("flush_e", 32'(ren_e_), 32'h3);
    flush_ = 1'b1; commit_e_ = '1; dec_e_ = 2'b10; dec_rob_id = 4'd8;
    dec_rd = '0; dec_rs1[0] = gpr(2); dec_rs2[0] = fpr(5);
    step();
    chk("flush_x2", 32'(ren_rs1[0]), 32'(gpr(2)));
    chk("flush_f5", 32'(ren_rs2[0]), 32'(fpr(5)));

    // Asynchronous reset pulse mid-stream.
    dec_rob_id = 4'd3; dec_rd[0] = gpr(1); dec_rs1[0] = gpr(0); dec_rs2[0] = gpr(0);
    step();
    dec_rob_id = 4'd4; dec_rd[0] = gpr(0); dec_rs1[0] = gpr(1);
    #2 reset = 1'b1;
    #1 chk_reset_outs("reset_pulse");
    #1 reset = 1'b0;
    model_clear();
    step();
    chk("post_reset_x1", 32'(ren_rs1[0]), 32'(gpr(1)));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      dec_e_      = DW'($urandom);
      dec_invalid = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
      flush_      = ($urandom_range(0, 15) != 0);
      commit_e_   = CW'($urandom);
      dec_rob_id  = 4'($urandom);
      for (int i = 0; i < DW; i++) begin
        dec_rd[i] = rnd_op(); dec_rs1[i] = rnd_op(); dec_rs2[i] = rnd_op();
      end
      for (int p = 0; p < CW; p++) com_rob_id[p] = 4'($urandom);
      step();
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
